// File: rtl/audio_pwm_sched.sv
// audio_pwm_sched: sample-period scheduler with demod FIFO, CPU source select and click-free mute ramps
module audio_pwm_sched #(
  parameter int SAMPLE_W   = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int STEP       = 64
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          enable,
  input  logic [SAMPLE_W-1:0]           period,
  input  logic                          src_sel,
  input  logic [SAMPLE_W-1:0]           demod_data,
  input  logic                          demod_valid,
  output logic                          demod_ready,
  input  logic [SAMPLE_W-1:0]           cpu_data,
  input  logic                          cpu_wr,
  input  logic                          mute_req,
  output logic [SAMPLE_W-1:0]           pwm_sample,
  output logic                          pwm_sync,
  output logic                          underrun,
  output logic                          muted,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RUN      = 3'd1;
  localparam logic [2:0] S_MUTING   = 3'd2;
  localparam logic [2:0] S_MUTED    = 3'd3;
  localparam logic [2:0] S_UNMUTING = 3'd4;
  localparam logic [SAMPLE_W:0] STEP_X = (SAMPLE_W+1)'(STEP);

  logic [2:0]          r_state, w_state;
  logic [SAMPLE_W-1:0] r_cnt, r_per, r_sample, r_last, r_cpu;
  logic [SAMPLE_W-1:0] w_per_in, w_sil, w_live, w_target, w_ramp, w_next;
  logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [AW:0]         r_level;
  logic                r_sync, r_under;
  logic                w_empty, w_full, w_push, w_pop, w_bnd, w_hold, w_close, w_above;
  logic [SAMPLE_W:0]   w_up, w_dn, w_diff;

  assign w_per_in = (period < SAMPLE_W'(2)) ? SAMPLE_W'(2) : period;
  assign w_sil    = r_per >> 1;
  assign w_empty  = r_level == '0;
  assign w_full   = r_level == (AW+1)'(FIFO_DEPTH);
  assign w_push   = demod_valid & ~w_full;
  // Holding (IDLE or being disabled) keeps the period latch transparent so a fresh enable starts on the current period.
  assign w_hold   = ~enable | (r_state == S_IDLE);
  assign w_bnd    = ~w_hold & (r_cnt == r_per - 1'b1);
  assign w_pop    = w_bnd & ~src_sel & ~w_empty;
  assign w_live   = src_sel ? r_cpu : (w_empty ? r_last : r_mem[r_rp]);
  assign w_target = mute_req ? w_sil : w_live;
  assign w_above  = r_sample > w_target;
  assign w_diff   = w_above ? {1'b0, r_sample} - {1'b0, w_target} : {1'b0, w_target} - {1'b0, r_sample};
  assign w_close  = w_diff <= STEP_X;
  assign w_up     = {1'b0, r_sample} + STEP_X;
  assign w_dn     = {1'b0, r_sample} - STEP_X;
  assign w_ramp   = w_close ? w_target :
                    w_above ? (w_dn[SAMPLE_W] ? '0 : w_dn[SAMPLE_W-1:0]) :
                              (w_up[SAMPLE_W] ? '1 : w_up[SAMPLE_W-1:0]);
  // The boundary's mute_req decides both the output and the next state, so a ramp starts on the same boundary.
  assign w_next   = mute_req ? ((r_state == S_MUTED) ? w_sil : w_ramp)
                             : ((r_state == S_RUN) ? w_live : w_ramp);
  assign w_state  = mute_req ? (((r_state == S_MUTED) | w_close) ? S_MUTED : S_MUTING)
                             : (((r_state == S_RUN) | w_close) ? S_RUN : S_UNMUTING);

  assign demod_ready = ~w_full;
  assign pwm_sample  = r_sample;
  assign pwm_sync    = r_sync;
  assign underrun    = r_under;
  assign muted       = r_state == S_MUTED;
  assign fifo_level  = r_level;

  // Scheduler: period counter, period latch, state machine and output sample.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_per    <= SAMPLE_W'(2);
      r_sample <= '0;
      r_last   <= '0;
      r_cpu    <= '0;
      r_sync   <= 1'b0;
      r_under  <= 1'b0;
    end else begin
      r_sync  <= w_bnd;
      r_under <= w_bnd & ~src_sel & w_empty;
      if (cpu_wr) r_cpu <= cpu_data;
      if (w_hold) begin
        r_state  <= ~enable ? S_IDLE : (mute_req ? S_MUTED : S_RUN);
        r_cnt    <= '0;
        r_per    <= w_per_in;
        r_sample <= w_per_in >> 1;
      end else if (w_bnd) begin
        r_state  <= w_state;
        r_cnt    <= '0;
        r_per    <= w_per_in;
        r_sample <= w_next;
        r_last   <= w_live;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // FIFO bookkeeping; a push into an empty FIFO is only visible to later fetches.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_level <= (w_push & ~w_pop) ? r_level + 1'b1 : (~w_push & w_pop) ? r_level - 1'b1 : r_level;
    end
  end

  // FIFO storage; contents become unreachable on reset since the pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= demod_data;
  end
endmodule

// File: tb/tb_audio_pwm_sched.sv
module tb_audio_pwm_sched;
  localparam int W = 14, D = 4, STEP = 64;
  localparam int IDLE = 0, RUN = 1, MUTING = 2, MUTED = 3, UNMUTING = 4;

  logic clk = 0, RST = 1, enable = 0, src_sel = 0, demod_valid = 0, cpu_wr = 0, mute_req = 0;
  logic [W-1:0] period = 100, demod_data = 0, cpu_data = 0;
  logic demod_ready, pwm_sync, underrun, muted;
  logic [W-1:0] pwm_sample;
  logic [2:0] fifo_level;

  int checks = 0, errors = 0;
  int q[$];
  int st, per, phase, e_sample, last, cpu;
  bit e_sync, e_under;
  int mute_exp[5] = '{736, 672, 608, 544, 500};
  int unmute_exp[5] = '{564, 628, 692, 756, 800};

  audio_pwm_sched #(.SAMPLE_W(W), .FIFO_DEPTH(D), .STEP(STEP)) dut (
    .clk(clk), .RST(RST), .enable(enable), .period(period), .src_sel(src_sel),
    .demod_data(demod_data), .demod_valid(demod_valid), .demod_ready(demod_ready),
    .cpu_data(cpu_data), .cpu_wr(cpu_wr), .mute_req(mute_req),
    .pwm_sample(pwm_sample), .pwm_sync(pwm_sync), .underrun(underrun),
    .muted(muted), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Reference model: apply the behaviour of one clock edge with the current inputs, then advance the clock.
  task automatic tick();
    int eff, lv, nt, d;
    bit bnd, push;
    int pv;
    eff = (period < 2) ? 2 : int'(period);
    bnd = enable && st != IDLE && phase == per - 1;
    push = demod_valid && q.size() < D;
    pv = int'(demod_data);
    e_sync = 0;
    e_under = 0;
    if (RST) begin
      q.delete();
      st = IDLE; per = 2; phase = 0; e_sample = 0; last = 0; cpu = 0;
    end else begin
      if (!enable || st == IDLE) begin
        st = !enable ? IDLE : (mute_req ? MUTED : RUN);
        phase = 0; per = eff; e_sample = eff / 2;
      end else if (!bnd) begin
        phase++;
      end else begin
        e_sync = 1;
        phase = 0;
        if (src_sel) lv = cpu;
        else if (q.size() > 0) lv = q.pop_front();
        else begin lv = last; e_under = 1; end
        last = lv;
        nt = mute_req ? per / 2 : lv;
        d = e_sample > nt ? e_sample - nt : nt - e_sample;
        if ((mute_req && st == MUTED) || (!mute_req && st == RUN)) e_sample = nt;
        else if (d <= STEP) begin e_sample = nt; st = mute_req ? MUTED : RUN; end
        else begin
          e_sample = e_sample > nt ? e_sample - STEP : e_sample + STEP;
          e_sample = e_sample < 0 ? 0 : (e_sample > 16383 ? 16383 : e_sample);
          st = mute_req ? MUTING : UNMUTING;
        end
        per = eff;
      end
      if (push) q.push_back(pv);
      if (cpu_wr) cpu = int'(cpu_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int v);
    demod_data = W'(v);
    demod_valid = 1;
    tick();
    demod_valid = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    tick();
    tick();
    checks++; if (pwm_sample !== 0) begin errors++; $display("FAIL reset_sample got %0d exp 0", pwm_sample); end
    checks++; if (pwm_sync !== 0) begin errors++; $display("FAIL reset_sync got %0d exp 0", pwm_sync); end
    checks++; if (underrun !== 0) begin errors++; $display("FAIL reset_underrun got %0d exp 0", underrun); end
    checks++; if (muted !== 0) begin errors++; $display("FAIL reset_muted got %0d exp 0", muted); end
    checks++; if (fifo_level !== 0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (demod_ready !== 1) begin errors++; $display("FAIL reset_ready got %0d exp 1", demod_ready); end
    RST = 0;
    tick();
  endtask

  task automatic test_steady();
    int n_sync, n_under;
    int got[$];
    int at[$];
    period = 100;
    src_sel = 0;
    push_word(1000);
    push_word(2000);
    push_word(3000);
    checks++; if (fifo_level !== 3) begin errors++; $display("FAIL steady_level got %0d exp 3", fifo_level); end
    enable = 1;
    tick();
    n_sync = 0; n_under = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      checks++; if (pwm_sync !== e_sync) begin errors++; $display("FAIL steady_sync k=%0d got %0d exp %0d", k, pwm_sync, e_sync); end
      checks++; if (pwm_sample !== W'(e_sample)) begin errors++; $display("FAIL steady_sample k=%0d got %0d exp %0d", k, pwm_sample, e_sample); end
      if (pwm_sync) begin got.push_back(int'(pwm_sample)); at.push_back(k); end
      if (underrun) n_under++;
    end
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL steady_nsync got %0d exp 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      checks++; if (got[i] !== (i + 1) * 1000) begin errors++; $display("FAIL steady_value i=%0d got %0d exp %0d", i, got[i], (i + 1) * 1000); end
      checks++; if (at[i] !== (i + 1) * 100) begin errors++; $display("FAIL steady_cycle i=%0d got %0d exp %0d", i, at[i], (i + 1) * 100); end
    end
    checks++; if (n_under !== 0) begin errors++; $display("FAIL steady_underrun got %0d exp 0", n_under); end
  endtask

  task automatic test_underrun();
    int n_under;
    n_under = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      checks++; if (underrun !== e_under) begin errors++; $display("FAIL under_pulse k=%0d got %0d exp %0d", k, underrun, e_under); end
      if (pwm_sync) begin
        checks++; if (pwm_sample !== 3000) begin errors++; $display("FAIL under_hold got %0d exp 3000", pwm_sample); end
      end
      if (underrun) n_under++;
    end
    checks++; if (n_under !== 2) begin errors++; $display("FAIL under_count got %0d exp 2", n_under); end
    checks++; if (fifo_level !== 0) begin errors++; $display("FAIL under_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_backpressure();
    int n;
    enable = 0;
    tick();
    for (int k = 0; k < 6; k++) begin
      demod_data = W'($urandom);
      demod_valid = 1;
      tick();
      checks++; if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL bp_level k=%0d got %0d exp %0d", k, fifo_level, q.size()); end
    end
    demod_valid = 0;
    checks++; if (fifo_level !== 4) begin errors++; $display("FAIL bp_full_level got %0d exp 4", fifo_level); end
    checks++; if (demod_ready !== 0) begin errors++; $display("FAIL bp_ready got %0d exp 0", demod_ready); end
    period = 20;
    enable = 1;
    tick();
    n = 0;
    while (q.size() != 2 && n < 200) begin
      tick(); n++;
      checks++; if (pwm_sample !== W'(e_sample)) begin errors++; $display("FAIL bp_sample got %0d exp %0d", pwm_sample, e_sample); end
    end
    n = 0;
    while (phase != per - 1 && n < 50) begin tick(); n++; end
    demod_data = W'($urandom);
    demod_valid = 1;
    tick();
    demod_valid = 0;
    checks++; if (pwm_sync !== 1) begin errors++; $display("FAIL bp_boundary got %0d exp 1", pwm_sync); end
    checks++; if (pwm_sample !== W'(e_sample)) begin errors++; $display("FAIL bp_pop_value got %0d exp %0d", pwm_sample, e_sample); end
    tick();
    checks++; if (fifo_level !== 2) begin errors++; $display("FAIL bp_pushpop_level got %0d exp 2", fifo_level); end
  endtask

  task automatic test_mute();
    int n;
    enable = 0;
    tick();
    period = 1000;
    src_sel = 1;
    cpu_data = 800;
    cpu_wr = 1;
    tick();
    cpu_wr = 0;
    enable = 1;
    tick();
    n = 0;
    do begin tick(); n++; end while (!pwm_sync && n < 2100);
    checks++; if (pwm_sample !== 800) begin errors++; $display("FAIL mute_live got %0d exp 800", pwm_sample); end
    mute_req = 1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin
        tick(); n++;
        checks++; if (pwm_sample !== W'(e_sample)) begin errors++; $display("FAIL mute_stable got %0d exp %0d", pwm_sample, e_sample); end
      end while (!pwm_sync && n < 2100);
      checks++; if (!pwm_sync) begin errors++; $display("FAIL mute_timeout got 0 exp 1"); end
      checks++; if (pwm_sample !== W'(mute_exp[i])) begin errors++; $display("FAIL mute_ramp i=%0d got %0d exp %0d", i, pwm_sample, mute_exp[i]); end
      checks++; if (muted !== (i == 4)) begin errors++; $display("FAIL mute_flag i=%0d got %0d exp %0d", i, muted, i == 4); end
    end
    mute_req = 0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin tick(); n++; end while (!pwm_sync && n < 2100);
      checks++; if (pwm_sample !== W'(unmute_exp[i])) begin errors++; $display("FAIL unmute_ramp i=%0d got %0d exp %0d", i, pwm_sample, unmute_exp[i]); end
      checks++; if (muted !== 0) begin errors++; $display("FAIL unmute_flag i=%0d got %0d exp 0", i, muted); end
    end
    checks++; if (st !== RUN) begin errors++; $display("FAIL unmute_state got %0d exp %0d", st, RUN); end
  endtask

  task automatic test_source();
    int n, lvl;
    enable = 0;
    tick();
    period = 50;
    lvl = q.size();
    cpu_data = 1234;
    cpu_wr = 1;
    src_sel = 1;
    enable = 1;
    tick();
    cpu_wr = 0;
    n = 0;
    do begin tick(); n++; end while (!pwm_sync && n < 120);
    checks++; if (pwm_sample !== 1234) begin errors++; $display("FAIL src_cpu got %0d exp 1234", pwm_sample); end
    checks++; if (fifo_level !== 3'(lvl)) begin errors++; $display("FAIL src_level got %0d exp %0d", fifo_level, lvl); end
    n = 0;
    while (phase != per - 1 && n < 60) begin tick(); n++; end
    cpu_data = 555;
    cpu_wr = 1;
    tick();
    cpu_wr = 0;
    checks++; if (pwm_sync !== 1) begin errors++; $display("FAIL src_coinc_sync got %0d exp 1", pwm_sync); end
    checks++; if (pwm_sample !== 1234) begin errors++; $display("FAIL src_coinc_old got %0d exp 1234", pwm_sample); end
    n = 0;
    do begin tick(); n++; end while (!pwm_sync && n < 120);
    checks++; if (pwm_sample !== 555) begin errors++; $display("FAIL src_new got %0d exp 555", pwm_sample); end
  endtask

  task automatic test_enable();
    int n, n_sync;
    enable = 0;
    tick();
    period = 200;
    enable = 1;
    tick();
    n = 0;
    do begin tick(); n++; end while (!pwm_sync && n < 450);
    checks++; if (pwm_sample !== 555) begin errors++; $display("FAIL en_run got %0d exp 555", pwm_sample); end
    mute_req = 1;
    n = 0;
    do begin tick(); n++; end while (!pwm_sync && n < 450);
    checks++; if (pwm_sample !== 491) begin errors++; $display("FAIL en_muting got %0d exp 491", pwm_sample); end
    enable = 0;
    tick();
    checks++; if (pwm_sample !== 100) begin errors++; $display("FAIL en_idle_sil got %0d exp 100", pwm_sample); end
    checks++; if (muted !== 0) begin errors++; $display("FAIL en_idle_muted got %0d exp 0", muted); end
    n_sync = 0;
    for (int k = 0; k < 450; k++) begin tick(); if (pwm_sync) n_sync++; end
    checks++; if (n_sync !== 0) begin errors++; $display("FAIL en_idle_nosync got %0d exp 0", n_sync); end
    mute_req = 0;
  endtask

  task automatic test_reset_mid();
    src_sel = 0;
    period = 30;
    enable = 1;
    for (int k = 0; k < 3; k++) push_word(int'($urandom_range(0, 16383)));
    for (int k = 0; k < 40; k++) tick();
    RST = 1;
    tick();
    checks++; if (pwm_sample !== 0) begin errors++; $display("FAIL rst_sample got %0d exp 0", pwm_sample); end
    checks++; if (pwm_sync !== 0) begin errors++; $display("FAIL rst_sync got %0d exp 0", pwm_sync); end
    checks++; if (fifo_level !== 0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    checks++; if (demod_ready !== 1) begin errors++; $display("FAIL rst_ready got %0d exp 1", demod_ready); end
    checks++; if (muted !== 0 || underrun !== 0) begin errors++; $display("FAIL rst_flags got %0d%0d exp 00", muted, underrun); end
    RST = 0;
    enable = 0;
    tick();
  endtask

  task automatic test_random();
    enable = 1;
    for (int k = 0; k < 4000; k++) begin
      demod_valid = $urandom_range(0, 3) == 0;
      demod_data = W'($urandom);
      cpu_wr = $urandom_range(0, 15) == 0;
      cpu_data = W'($urandom);
      if ($urandom_range(0, 199) == 0) src_sel = ~src_sel;
      if ($urandom_range(0, 149) == 0) mute_req = ~mute_req;
      if ($urandom_range(0, 299) == 0) period = W'($urandom_range(0, 40));
      enable = $urandom_range(0, 499) != 0;
      tick();
      checks++; if (pwm_sample !== W'(e_sample)) begin errors++; $display("FAIL rnd_sample k=%0d got %0d exp %0d", k, pwm_sample, e_sample); end
      checks++; if (pwm_sync !== e_sync) begin errors++; $display("FAIL rnd_sync k=%0d got %0d exp %0d", k, pwm_sync, e_sync); end
      checks++; if (underrun !== e_under) begin errors++; $display("FAIL rnd_underrun k=%0d got %0d exp %0d", k, underrun, e_under); end
      checks++; if (muted !== (st == MUTED)) begin errors++; $display("FAIL rnd_muted k=%0d got %0d exp %0d", k, muted, st == MUTED); end
      checks++; if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level k=%0d got %0d exp %0d", k, fifo_level, q.size()); end
      checks++; if (demod_ready !== (q.size() < D)) begin errors++; $display("FAIL rnd_ready k=%0d got %0d exp %0d", k, demod_ready, q.size() < D); end
    end
    demod_valid = 0;
    cpu_wr = 0;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_underrun();
    test_backpressure();
    test_mute();
    test_source();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
